prng_step_arbiter: RTL and testbench
====================================

// Module: prng_step_arbiter
// PURPOSE
//  Sequencer and round-robin arbiter for the PRNG core (LCG state + xorshift/rotate permutation stage).
//  Owns seeding, warm-up stepping and per-word advance of the LCG.
//  Shares the permuted 128-bit output among NUM_REQ requesters, one word per grant, valid/ready handshake.
//  Sits between the consumer fabric and the LCG/permutation pair.
// PARAMETERS
//  NUM_REQ       4    number of requesters (>=2)
//  WIDTH         128  LCG state / permuted word width
//  PERM_LAT      1    cycles from step_o pulse to valid perm_data_i (>=1)
//  WARMUP_STEPS  8    discarded steps after every seed load (0 = no warm-up)
// PORTS
//  clk           in   1            clock, rising edge
//  rst           in   1            reset, asynchronous, active-low
//  seed_valid_i  in   1            new seed offered
//  seed_ready_o  out  1            seed accepted when valid&ready
//  seed_i        in   WIDTH        seed value
//  seed_load_o   out  1            1-cycle pulse: LCG loads seed_data_o
//  seed_data_o   out  WIDTH        registered copy of accepted seed
//  step_o        out  1            1-cycle pulse: LCG advances one state
//  perm_data_i   in   WIDTH        permutation output, sampled PERM_LAT cycles after step_o
//  req_i         in   NUM_REQ      per-requester word request (level)
//  gnt_o         out  NUM_REQ      one-hot grant, held with rsp_valid_o
//  rsp_valid_o   out  1            rsp_data_o valid for granted requester
//  rsp_data_o    out  WIDTH        random word
//  rsp_ready_i   in   1            granted requester accepts word
//  busy_o        out  1            1 in any state except IDLE/RUN-idle
// BEHAVIOUR
//  Reset: state=UNSEEDED; all outputs 0 (seed_ready_o=0 during reset, 1 on first cycle after release); rr_ptr=0.
//  States: UNSEEDED, LOAD, WARMUP, RUN_IDLE, RUN_WAIT, RUN_HOLD.
//  UNSEEDED: seed_ready_o=1; req_i ignored (no grant). seed handshake -> capture seed_i, go LOAD.
//  LOAD: seed_load_o=1 for exactly 1 cycle; -> WARMUP if WARMUP_STEPS>0 else RUN_IDLE.
//  WARMUP: one step_o every PERM_LAT+1 cycles, WARMUP_STEPS pulses total; perm_data_i discarded; -> RUN_IDLE.
//  RUN_IDLE: seed_ready_o=1. Seed handshake has priority over req_i in the same cycle -> LOAD.
//    Else if |req_i: pick first set req at or after rr_ptr (wrap NUM_REQ-1 -> 0), latch one-hot grant,
//    pulse step_o, load latency counter = PERM_LAT, -> RUN_WAIT.
//  RUN_WAIT: counter decrements each cycle; at 0 sample perm_data_i into rsp_data_o, rsp_valid_o=1,
//    gnt_o=latched grant, -> RUN_HOLD. Requester dropping req_i here does not cancel; word still offered.
//  RUN_HOLD: rsp_valid_o, gnt_o, rsp_data_o stable until rsp_ready_i. On handshake: rsp_valid_o=0,
//    gnt_o=0 next cycle, rr_ptr = granted index+1 (mod NUM_REQ), -> RUN_IDLE.
//  seed_ready_o=0 in LOAD, WARMUP, RUN_WAIT, RUN_HOLD (no reseed mid-word).
//  Throughput: one word per PERM_LAT+2 cycles minimum (grant, wait, hold w/ ready=1).
//  Each LCG state is delivered at most once; words never duplicated across requesters.
//  Async reset mid-operation: immediate return to reset values; LCG considered unseeded; pending word dropped.
//  Counters sized $clog2(max+1); no overflow; WARMUP_STEPS=0 and PERM_LAT=1 are legal boundaries.
// CONFIGURATION
//  PRNG_REPEAT_CHECK_EN defined: extra port err_o (out, 1). Each sampled perm_data_i (RUN only) compared
//    with previous delivered word; equal -> err_o=1 sticky, word not presented, FSM parks in RUN_IDLE
//    issuing no grants until reseed (seed load clears err_o and the previous-word register).
//  Not defined: no err_o port, no comparison register, words delivered unconditionally.
// TESTING
//  1 Reset release, req_i=4'b1111, no seed -> gnt_o=0, step_o never pulses, seed_ready_o=1.
//  2 Seed 128'h1, WARMUP_STEPS=8, PERM_LAT=1 -> one seed_load_o pulse, exactly 8 step_o pulses 2 cycles apart, then RUN_IDLE.
//  3 req_i=4'b1111, rsp_ready_i=1 constant -> gnt_o order 0001,0010,0100,1000,0001; one step_o per grant; words match reference model.
//  4 Grant to req 2, rsp_ready_i held 0 for 10 cycles -> rsp_data_o/gnt_o=0100 stable, seed_ready_o=0, no further step_o.
//  5 seed_valid_i and req_i=4'b0001 same cycle in RUN_IDLE -> seed taken, no grant, warm-up rerun before next grant.
//  6 Assert rst in RUN_WAIT -> all outputs 0 async; after release state UNSEEDED; PRNG_REPEAT_CHECK_EN build: force perm_data_i constant -> err_o=1, grants stop until reseed.

Source files
------------

// File: rtl/prng_step_arbiter_if.sv
// prng_step_arbiter_if: seed and requester/response handshake bundle (slave = arbiter side)
interface prng_step_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
);
  logic               seed_valid_i;
  logic               seed_ready_o;
  logic [WIDTH-1:0]   seed_i;
  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic               rsp_valid_o;
  logic [WIDTH-1:0]   rsp_data_o;
  logic               rsp_ready_i;
  modport slave (
    input  seed_valid_i, seed_i, req_i, rsp_ready_i,
    output seed_ready_o, gnt_o, rsp_valid_o, rsp_data_o
  );
  modport master (
    output seed_valid_i, seed_i, req_i, rsp_ready_i,
    input  seed_ready_o, gnt_o, rsp_valid_o, rsp_data_o
  );
endinterface

// File: rtl/prng_step_arbiter.sv
// prng_step_arbiter: PRNG seeding/warm-up sequencer and round-robin word arbiter; PRNG_REPEAT_CHECK_EN adds err_o repeat detection
module prng_step_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 128,
  parameter int PERM_LAT     = 1,
  parameter int WARMUP_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  prng_step_arbiter_if.slave bus,
  output logic             seed_load_o,
  output logic [WIDTH-1:0] seed_data_o,
  output logic             step_o,
  input  logic [WIDTH-1:0] perm_data_i,
  output logic             busy_o
`ifdef PRNG_REPEAT_CHECK_EN
  ,
  output logic             err_o
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(PERM_LAT + 1);
  localparam int WW = WARMUP_STEPS > 0 ? $clog2(WARMUP_STEPS + 1) : 1;
  localparam logic [CW-1:0] PL_C = CW'(PERM_LAT);
  localparam logic [WW-1:0] WS_C = WW'(WARMUP_STEPS);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {UNSEEDED, LOAD, WARMUP, RUN_IDLE, RUN_WAIT, RUN_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] rsp_q, rsp_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [PW-1:0]    pick, k;
  logic             found, seed_hs, blocked;

`ifdef PRNG_REPEAT_CHECK_EN
  logic             err_q, err_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_v_q, prev_v_d;
  assign blocked = err_q;
  assign err_o   = err_q;
`else
  assign blocked = 1'b0;
`endif

  assign bus.seed_ready_o = rst & (state_q == UNSEEDED || state_q == RUN_IDLE);
  assign seed_hs          = bus.seed_valid_i & bus.seed_ready_o;
  assign seed_load_o      = state_q == LOAD;
  assign seed_data_o      = seed_q;
  assign bus.rsp_valid_o  = state_q == RUN_HOLD;
  assign bus.gnt_o        = bus.rsp_valid_o ? NUM_REQ'(1) << gidx_q : '0;
  assign bus.rsp_data_o   = rsp_q;
  assign busy_o           = !(state_q == UNSEEDED || state_q == RUN_IDLE);

  // round-robin search: first active request at or after rr_q, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    k     = rr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_i[k]) begin
        found = 1'b1;
        pick  = k;
      end
      k = (k == LAST) ? '0 : k + 1'b1;
    end
  end

  // next-state, step pulse and datapath updates
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    rsp_d   = rsp_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    step_o  = 1'b0;
`ifdef PRNG_REPEAT_CHECK_EN
    err_d    = err_q;
    prev_d   = prev_q;
    prev_v_d = prev_v_q;
`endif
    case (state_q)
      UNSEEDED: begin
        if (seed_hs) begin
          seed_d  = bus.seed_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        wcnt_d  = '0;
        state_d = WARMUP_STEPS > 0 ? WARMUP : RUN_IDLE;
`ifdef PRNG_REPEAT_CHECK_EN
        err_d    = 1'b0;
        prev_d   = '0;
        prev_v_d = 1'b0;
`endif
      end
      WARMUP: begin
        step_o  = cnt_q == '0;
        cnt_d   = (cnt_q == PL_C) ? '0 : cnt_q + 1'b1;
        wcnt_d  = wcnt_q + WW'(step_o);
        state_d = (cnt_q == PL_C && wcnt_q == WS_C) ? RUN_IDLE : WARMUP;
      end
      RUN_IDLE: begin
        if (seed_hs) begin
          seed_d  = bus.seed_i;
          state_d = LOAD;
        end else if (found && !blocked) begin
          gidx_d  = pick;
          step_o  = 1'b1;
          cnt_d   = PL_C;
          state_d = RUN_WAIT;
        end
      end
      RUN_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
`ifdef PRNG_REPEAT_CHECK_EN
          if (prev_v_q && perm_data_i == prev_q) begin
            err_d   = 1'b1;
            state_d = RUN_IDLE;
          end else begin
            rsp_d    = perm_data_i;
            prev_d   = perm_data_i;
            prev_v_d = 1'b1;
            state_d  = RUN_HOLD;
          end
`else
          rsp_d   = perm_data_i;
          state_d = RUN_HOLD;
`endif
        end
      end
      RUN_HOLD: begin
        if (bus.rsp_ready_i) begin
          rr_d    = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
          state_d = RUN_IDLE;
        end
      end
      default: state_d = UNSEEDED;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= UNSEEDED;
      seed_q   <= '0;
      rsp_q    <= '0;
      gidx_q   <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      wcnt_q   <= '0;
`ifdef PRNG_REPEAT_CHECK_EN
      err_q    <= 1'b0;
      prev_q   <= '0;
      prev_v_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      rsp_q    <= rsp_d;
      gidx_q   <= gidx_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
`ifdef PRNG_REPEAT_CHECK_EN
      err_q    <= err_d;
      prev_q   <= prev_d;
      prev_v_q <= prev_v_d;
`endif
    end
  end
endmodule

// File: tb/tb_prng_step_arbiter.sv
// tb_prng_step_arbiter: directed vectors against an LCG/permutation reference for prng_step_arbiter
module tb_prng_step_arbiter;
  localparam int NR = 4;
  localparam int W  = 128;
  localparam int PL = 1;
  localparam int WS = 8;
  localparam logic [W-1:0] LA = 128'h2360ED051FC65DA44385DF649FCCF645;
  localparam logic [W-1:0] LC = 128'h5851F42D4C957F2D14057B7EF767814F;
  localparam logic [W-1:0] S1 = 128'h1;
  localparam logic [W-1:0] S2 = 128'hDEADBEEF_0123_4567_89AB_CDEF_1357_9BDF;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prng_step_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
  logic         seed_load, step, busy;
  logic [W-1:0] seed_data, perm_data, lcg_q;
`ifdef PRNG_REPEAT_CHECK_EN
  localparam logic [W-1:0] STUCK = 128'h5A5A;
  logic err;
  logic stuck = 1'b0;
`endif

  prng_step_arbiter #(.NUM_REQ(NR), .WIDTH(W), .PERM_LAT(PL), .WARMUP_STEPS(WS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .seed_load_o (seed_load),
    .seed_data_o (seed_data),
    .step_o      (step),
    .perm_data_i (perm_data),
    .busy_o      (busy)
`ifdef PRNG_REPEAT_CHECK_EN
    ,
    .err_o       (err)
`endif
  );

  function automatic logic [W-1:0] lcg(input logic [W-1:0] x);
    return x * LA + LC;
  endfunction

  function automatic logic [W-1:0] perm(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x ^ (x >> 61);
    return {y[88:0], y[127:89]} ^ (y << 7);
  endfunction

  function automatic logic [W-1:0] model_word(input logic [W-1:0] s, input int n);
    logic [W-1:0] x;
    x = s;
    for (int i = 0; i < n; i++) x = lcg(x);
    return perm(x);
  endfunction

  // LCG + permutation environment driven by the DUT's load/step pulses
  always @(posedge clk) begin
    if (seed_load) lcg_q <= seed_data;
    else if (step) lcg_q <= lcg(lcg_q);
  end
`ifdef PRNG_REPEAT_CHECK_EN
  assign perm_data = stuck ? STUCK : perm(lcg_q);
`else
  assign perm_data = perm(lcg_q);
`endif

  int cyc = 0, steps = 0, loads = 0;
  int step_t[256];
  always @(posedge clk) begin
    cyc++;
    if (step) begin
      if (steps < 256) step_t[steps] = cyc;
      steps++;
    end
    if (seed_load) loads++;
  end

  int checks = 0, errors = 0;
  int wk = 0;
  logic [W-1:0] cur_seed;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_seed(input logic [W-1:0] s);
    bus.seed_valid_i = 1'b1;
    bus.seed_i       = s;
    @(negedge clk);
    bus.seed_valid_i = 1'b0;
    cur_seed = s;
    wk = 0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    chk(nm, W'(done), W'(1));
  endtask

  task automatic wait_valid(input string nm, input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      got = bus.rsp_valid_o;
    end
    chk(nm, W'(got), W'(1));
  endtask

  task automatic do_word(input logic [NR-1:0] req, input logic [NR-1:0] eg, input string nm);
    int s0;
    bit got;
    s0 = steps;
    bus.req_i       = req;
    bus.rsp_ready_i = 1'b1;
    wait_valid({nm, "_valid"}, 20, got);
    wk++;
    chk({nm, "_gnt"}, W'(bus.gnt_o), W'(eg));
    chk({nm, "_data"}, bus.rsp_data_o, model_word(cur_seed, WS + wk));
    chk({nm, "_steps"}, W'(steps - s0), W'(1));
    bus.req_i = '0;
    @(negedge clk);
    chk({nm, "_drop"}, W'({bus.rsp_valid_o, bus.gnt_o}), W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    int   s0, l0;
    bit   got, bad;
    logic [W-1:0] hold_word;
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b1111, 4'b0100};
    tbl[3] = '{4'b1111, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001};
    tbl[5] = '{4'b1001, 4'b1000};
    tbl[6] = '{4'b1001, 4'b0001};
    tbl[7] = '{4'b0001, 4'b0001};
    tbl[8] = '{4'b0110, 4'b0010};
    tbl[9] = '{4'b0010, 4'b0010};
    bus.seed_valid_i = 1'b0;
    bus.seed_i       = '0;
    bus.req_i        = '0;
    bus.rsp_ready_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seed_ready", W'(bus.seed_ready_o), W'(0));
    chk("rst_outputs", W'({bus.gnt_o, bus.rsp_valid_o, step, seed_load, busy}), W'(0));
    chk("rst_rsp_data", bus.rsp_data_o, W'(0));
    // test 1: requests before any seed are ignored
    bus.req_i = 4'b1111;
    rst = 1'b1;
    s0 = steps;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt_o != 0 || bus.rsp_valid_o) bad = 1;
    end
    chk("t1_no_grant", W'(bad), W'(0));
    chk("t1_no_step", W'(steps - s0), W'(0));
    chk("t1_seed_ready", W'(bus.seed_ready_o), W'(1));
    chk("t1_busy", W'(busy), W'(0));
    // test 2: seed load then 8 warm-up steps spaced PL+1 apart
    bus.req_i = '0;
    s0 = steps;
    l0 = loads;
    do_seed(S1);
    chk("t2_load_pulse", W'(seed_load), W'(1));
    chk("t2_seed_data", seed_data, S1);
    @(negedge clk);
    chk("t2_warm_busy", W'({busy, bus.seed_ready_o}), W'(2'b10));
    wait_idle("t2_idle");
    chk("t2_loads", W'(loads - l0), W'(1));
    chk("t2_steps", W'(steps - s0), W'(WS));
    for (int i = 1; i < WS; i++) chk("t2_gap", W'(step_t[s0 + i] - step_t[s0 + i - 1]), W'(PL + 1));
    // test 3: round-robin table
    for (int i = 0; i < 10; i++) do_word(tbl[i].req, tbl[i].gnt, $sformatf("t3_%0d", i));
    // test 4: grant to requester 2, response held while not ready
    s0 = steps;
    bus.req_i       = 4'b0100;
    bus.rsp_ready_i = 1'b0;
    wait_valid("t4_valid", 20, got);
    wk++;
    hold_word = model_word(cur_seed, WS + wk);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.gnt_o !== 4'b0100 || bus.rsp_data_o !== hold_word || !bus.rsp_valid_o || bus.seed_ready_o) bad = 1;
    end
    chk("t4_stable", W'(bad), W'(0));
    chk("t4_data", bus.rsp_data_o, hold_word);
    chk("t4_steps", W'(steps - s0), W'(1));
    bus.req_i       = '0;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("t4_release", W'({bus.rsp_valid_o, bus.gnt_o}), W'(0));
    // test 5: seed wins over a same-cycle request; warm-up reruns first
    s0 = steps;
    bus.req_i = 4'b0001;
    do_seed(S2);
    chk("t5_load", W'(seed_load), W'(1));
    chk("t5_no_grant", W'({bus.gnt_o, bus.rsp_valid_o}), W'(0));
    chk("t5_no_step", W'(steps - s0), W'(0));
    wait_valid("t5_valid", 60, got);
    chk("t5_gnt", W'(bus.gnt_o), W'(4'b0001));
    chk("t5_steps", W'(steps - s0), W'(WS + 1));
    chk("t5_data", bus.rsp_data_o, model_word(S2, WS + 1));
    bus.req_i = '0;
    @(negedge clk);
    // test 6: asynchronous reset in RUN_WAIT
    bus.req_i = 4'b0010;
    @(negedge clk);
    chk("t6_in_wait", W'({busy, bus.rsp_valid_o}), W'(2'b10));
    #2 rst = 1'b0;
    #1;
    chk("t6_async_outputs", W'({bus.gnt_o, bus.rsp_valid_o, step, seed_load, busy, bus.seed_ready_o}), W'(0));
    chk("t6_async_data", bus.rsp_data_o | seed_data, W'(0));
    @(negedge clk);
    bus.req_i = 4'b1111;
    rst = 1'b1;
    s0 = steps;
    repeat (5) @(negedge clk);
    chk("t6_unseeded_step", W'(steps - s0), W'(0));
    chk("t6_unseeded", W'({bus.gnt_o, busy, bus.seed_ready_o}), W'(1));
`ifdef PRNG_REPEAT_CHECK_EN
    bus.req_i = '0;
    do_seed(S1);
    wait_idle("t7_idle");
    stuck = 1'b1;
    bus.req_i       = 4'b0001;
    bus.rsp_ready_i = 1'b1;
    wait_valid("t7_first_valid", 20, got);
    chk("t7_first_data", bus.rsp_data_o, STUCK);
    bus.req_i = '0;
    @(negedge clk);
    s0 = steps;
    bus.req_i = 4'b0001;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid_o) bad = 1;
    end
    chk("t7_err", W'(err), W'(1));
    chk("t7_no_word", W'(bad), W'(0));
    chk("t7_one_step", W'(steps - s0), W'(1));
    bus.req_i = '0;
    do_seed(S2);
    @(negedge clk);
    chk("t7_err_clear", W'(err), W'(0));
    stuck = 1'b0;
    wait_idle("t7_idle2");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
